// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one divider among NREQ requesters;
// divide-by-zero requests are answered locally without starting the divider.
module div_arbiter #(
    parameter int BITS = 32,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic [NREQ-1:0]      req_rdy,
    output logic [NREQ-1:0]      resp_vld,
    output logic [BITS-1:0]      resp_q,
    output logic [BITS-1:0]      resp_r,
    output logic                 resp_dz,
    output logic [BITS-1:0]      div_a,
    output logic [BITS-1:0]      div_b,
    output logic                 div_input_vld,
    input  logic                 div_output_vld,
    input  logic [BITS-1:0]      div_q,
    input  logic [BITS-1:0]      div_r
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DZ, RESP} state_t;
    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, gnt;
    logic [BITS-1:0] a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d, sel_a, sel_b;
    logic            dz_q, dz_d, found, accept;
    logic [PW:0]     sum [NREQ];
    logic [PW-1:0]   cand [NREQ];
    // cand[k] is the k-th index in cyclic search order starting at ptr
    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign sum[k]  = {1'b0, ptr_q} + (PW+1)'(k);
        assign cand[k] = sum[k] >= (PW+1)'(NREQ) ? PW'(sum[k] - (PW+1)'(NREQ)) : PW'(sum[k]);
    end
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_vld[cand[k]]) begin
                gnt   = cand[k];
                found = 1'b1;
            end
        end
    end
    assign sel_a         = req_a[gnt*BITS +: BITS];
    assign sel_b         = req_b[gnt*BITS +: BITS];
    assign accept        = state_q == IDLE && found && !rst;
    assign req_rdy       = accept ? NREQ'(1) << gnt : '0;
    assign resp_vld      = (state_q == RESP && !rst) ? NREQ'(1) << owner_q : '0;
    assign resp_q        = q_q;
    assign resp_r        = r_q;
    assign resp_dz       = dz_q;
    assign div_a         = a_q;
    assign div_b         = b_q;
    // Never start the divider unless it reports idle, even after a reset mid-operation
    assign div_input_vld = state_q == ISSUE && div_output_vld && !rst;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (accept) begin
                a_d     = sel_a;
                b_d     = sel_b;
                owner_d = gnt;
                ptr_d   = gnt == PW'(NREQ - 1) ? '0 : gnt + 1'b1;
                state_d = sel_b == '0 ? DZ : ISSUE;
            end
            ISSUE: state_d = div_output_vld ? WAIT : ISSUE;
            WAIT: if (div_output_vld) begin
                q_d     = div_q;
                r_d     = div_r;
                state_d = RESP;
            end
            DZ: begin
                q_d     = '1;
                r_d     = a_q;
                dz_d    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                dz_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: vector table, hand sequences and random rounds against a
// grant/result reference model, with a behavioural shared divider attached.
module tb_div_arbiter;
    localparam int BITS = 32;
    localparam int NREQ = 4;
    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_vld, req_rdy, resp_vld;
    logic [NREQ*BITS-1:0] req_a, req_b;
    logic [BITS-1:0]      resp_q, resp_r, div_a, div_b, div_q, div_r;
    logic                 resp_dz, div_input_vld, div_output_vld;
    int                   checks = 0, errors = 0, pulses = 0, mptr = 0;
    logic [NREQ-1:0]      pend;
    logic [BITS-1:0]      op_a [NREQ];
    logic [BITS-1:0]      op_b [NREQ];

    typedef struct {
        int              idx;
        logic [BITS-1:0] a, b, q, r;
        logic            dz;
        int              lat;
    } vec_t;
    vec_t tbl [4];

    div_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
        .req_rdy(req_rdy), .resp_vld(resp_vld), .resp_q(resp_q), .resp_r(resp_r),
        .resp_dz(resp_dz), .div_a(div_a), .div_b(div_b), .div_input_vld(div_input_vld),
        .div_output_vld(div_output_vld), .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    // Divider model: no reset, busy for BITS+1 cycles after an accepted start
    logic            dv_idle = 1'b1;
    int              dv_cnt = 0;
    logic [BITS-1:0] dv_q = '0, dv_r = '0;
    assign div_output_vld = dv_idle;
    assign div_q = dv_idle ? dv_q : 32'hDEAD_BEEF;
    assign div_r = dv_idle ? dv_r : 32'hBAAD_F00D;
    always @(posedge clk) begin
        if (div_input_vld && dv_idle) begin
            dv_idle <= 1'b0;
            dv_cnt  <= BITS + 1;
            dv_q    <= BITS'($signed(div_a) / $signed(div_b));
            dv_r    <= BITS'($signed(div_a) % $signed(div_b));
        end else if (!dv_idle) begin
            if (dv_cnt == 1) dv_idle <= 1'b1;
            dv_cnt <= dv_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (div_input_vld) begin
            pulses++;
            checks++;
            if (!div_output_vld) begin
                errors++;
                $display("FAIL issue_to_busy: div_output_vld=%0b required 1", div_output_vld);
            end
        end
    end

    function automatic logic [BITS-1:0] ref_q(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return b == '0 ? '1 : BITS'($signed(a) / $signed(b));
    endfunction

    function automatic logic [BITS-1:0] ref_r(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return b == '0 ? a : BITS'($signed(a) % $signed(b));
    endfunction

    function automatic int next_grant(input logic [NREQ-1:0] p, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (p[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*BITS +: BITS] = op_a[i];
            req_b[i*BITS +: BITS] = op_b[i];
        end
        req_vld = pend;
    endtask

    // Called in an IDLE cycle with pend/op_* set up; expects requester g to win
    task automatic serve_one(input int g, input logic [BITS-1:0] eq, input logic [BITS-1:0] er,
                             input logic edz, input int elat);
        int n, p0;
        drive();
        #1;
        p0 = pulses;
        chk("grant", 32'(req_rdy), 32'(1 << g));
        @(posedge clk);
        #1;
        pend[g] = 1'b0;
        drive();
        mptr = (g + 1) % NREQ;
        #1;
        chk("rdy_busy", 32'(req_rdy), 0);
        n = 1;
        while (resp_vld == '0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (resp_vld == '0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: requester %0d got no resp_vld within %0d cycles", g, n);
        end else begin
            chk("latency", n, elat);
            chk("resp_owner", 32'(resp_vld), 32'(1 << g));
            chk("resp_q", resp_q, eq);
            chk("resp_r", resp_r, er);
            chk("resp_dz", 32'(resp_dz), 32'(edz));
            chk("issue_pulses", pulses - p0, edz ? 0 : 1);
        end
        @(posedge clk);
        #1;
        chk("resp_one_cycle", 32'(resp_vld), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 36};
        tbl[1] = '{2, -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 36};
        tbl[2] = '{2, 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 36};
        tbl[3] = '{1, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 2};
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 32'(1000 * (i + 1) + 7 * i);
            op_b[i] = i == 2 ? -32'sd5 : 32'(i + 3);
        end
        // All requesters pending through reset
        rst  = 1'b1;
        pend = '1;
        drive();
        @(posedge clk);
        #1;
        chk("rdy_in_reset", 32'(req_rdy), 0);
        chk("reset_resp_vld", 32'(resp_vld), 0);
        chk("reset_resp_q", resp_q, 0);
        chk("reset_resp_r", resp_r, 0);
        chk("reset_resp_dz", 32'(resp_dz), 0);
        chk("reset_div_a", div_a, 0);
        chk("reset_div_b", div_b, 0);
        chk("reset_div_start", 32'(div_input_vld), 0);
        rst  = 1'b0;
        mptr = 0;
        for (int i = 0; i < NREQ; i++)
            serve_one(i, ref_q(op_a[i], op_b[i]), ref_r(op_a[i], op_b[i]), 1'b0, BITS + 4);
        for (int t = 0; t < 4; t++) begin
            pend = '0;
            pend[tbl[t].idx] = 1'b1;
            op_a[tbl[t].idx] = tbl[t].a;
            op_b[tbl[t].idx] = tbl[t].b;
            serve_one(tbl[t].idx, tbl[t].q, tbl[t].r, tbl[t].dz, tbl[t].lat);
        end
        // Pointer now sits at 2: requester 3 must beat requester 0
        pend    = 4'b1001;
        op_a[0] = 32'd21;
        op_b[0] = 32'd4;
        op_a[3] = -32'sd21;
        op_b[3] = 32'd4;
        serve_one(3, -32'sd5, -32'sd1, 1'b0, 36);
        serve_one(0, 32'd5, 32'd1, 1'b0, 36);
        repeat (30) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = $urandom;
                case ($urandom_range(0, 3))
                    0:       op_b[i] = '0;
                    1:       op_b[i] = 32'($urandom_range(0, 20)) - 32'd10;
                    default: op_b[i] = $urandom;
                endcase
                if (op_a[i] == 32'h8000_0000 && op_b[i] == '1) op_b[i] = 32'd1;
            end
            while (pend != '0) begin
                int g;
                g = next_grant(pend, mptr);
                serve_one(g, ref_q(op_a[g], op_b[g]), ref_r(op_a[g], op_b[g]),
                          op_b[g] == '0, op_b[g] == '0 ? 2 : BITS + 4);
            end
        end
        // Reset ten cycles after ISSUE while the divider is still busy
        pend    = 4'b0001;
        op_a[0] = 32'd1000;
        op_b[0] = 32'd7;
        drive();
        #1;
        chk("midop_grant", 32'(req_rdy), 1);
        @(posedge clk);
        #1;
        chk("midop_issue", 32'(div_input_vld), 1);
        pend = '0;
        drive();
        repeat (10) @(posedge clk);
        #1;
        rst     = 1'b1;
        pend    = 4'b0001;
        op_a[0] = 32'd9;
        op_b[0] = 32'd3;
        drive();
        #1;
        chk("rdy_in_reset_midop", 32'(req_rdy), 0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mptr = 0;
        serve_one(0, 32'd3, 32'd0, 1'b0, 58);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one `div` instance among `NREQ` requesters. It accepts a signed divide request from one requester at a time and issues it to the divider with a single-cycle `input_vld` pulse. It then waits for the divider to finish and returns quotient and remainder to the owning requester. Divide-by-zero requests are answered locally without touching the divider. The block sits between the calculator front-end units and the shared `div` datapath.

## Interface
- `BITS`, 32, operand width; must equal the divider's operand width.
- `NREQ`, 4, number of requesters, 2..8.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_vld`  in  NREQ  requester i has an operation pending; held until accepted.
- `req_a`  in  NREQ*BITS  dividends, requester i at bits [i*BITS +: BITS], two's complement.
- `req_b`  in  NREQ*BITS  divisors, same packing.
- `req_rdy`  out  NREQ  one-hot acceptance strobe; a request transfers on a cycle with `req_vld[i] & req_rdy[i]`.
- `resp_vld`  out  NREQ  one-hot, one-cycle pulse to the owning requester.
- `resp_q`  out  BITS  quotient, valid while any `resp_vld` bit is high.
- `resp_r`  out  BITS  remainder, valid while any `resp_vld` bit is high.
- `resp_dz`  out  1  divide-by-zero flag, qualified by `resp_vld`.
- `div_a`, `div_b`  out  BITS  operands to the divider; held stable from ISSUE until the response.
- `div_input_vld`  out  1  start pulse to the divider.
- `div_output_vld`  in  1  divider idle/done level; high means idle.
- `div_q`, `div_r`  in  BITS  divider results.

## Operation
- States and transitions:
  - IDLE: if any `req_vld` is set, grant the first requesting index at or after `ptr`, searching cyclically. `req_rdy[g]`=1 combinationally in this cycle only.
  - On the accepting edge, capture `req_a`/`req_b` of g into `a_r`/`b_r` and record `owner`=g. Set `ptr`=(g+1) mod NREQ.
  - From IDLE, go to DZ if `b_r`==0, else go to ISSUE.
  - ISSUE: `div_input_vld`=1 only in a cycle where `div_output_vld`=1. If `div_output_vld`=0, stay in ISSUE with `div_input_vld`=0. Go to WAIT on the pulse cycle.
  - WAIT: stay while `div_output_vld`=0. When it is high, capture `div_q`/`div_r` into `q_r`/`r_r` and go to RESP.
  - DZ: load `q_r`=all ones, `r_r`=`a_r`, `dz_r`=1, and go to RESP.
  - RESP: `resp_vld[owner]`=1 for one cycle, `resp_q`=`q_r`, `resp_r`=`r_r`, `resp_dz`=`dz_r`. Clear `dz_r` and return to IDLE.
- `req_rdy` is 0 in every state except IDLE, so only one operation is in flight at a time.
- A new grant is possible in the cycle after RESP.
- Operands pass through unchanged. The divider performs the sign handling; the arbiter does no arithmetic except the zero compare.
- `div_a`/`div_b` are driven from `a_r`/`b_r` at all times.
- Reset values:
  - State is IDLE, `ptr`=0, `owner`=0.
  - `req_rdy`=0 during the reset cycle, and `resp_vld`=0.
  - `resp_q`, `resp_r`, `div_a`, `div_b` are 0; `resp_dz`=0; `div_input_vld`=0.

## Timing
- Acceptance takes 0 cycles of wait when the block is idle; the grant is visible in the same cycle as `req_vld`.
- With the divider idle, if acceptance is at cycle 0:
  - ISSUE pulse occurs at cycle 1.
  - The divider is busy for cycles 2..BITS+2.
  - `div_output_vld` rises at cycle BITS+3.
  - `resp_vld` is at cycle BITS+4; for BITS=32 that is cycle 36.
- DZ path: `resp_vld` at cycle 2.
- The WAIT state must not sample `div_output_vld` in the ISSUE cycle itself, because the level is still high from idle.
- The divider drops `div_output_vld` on the edge that ends ISSUE.
- Simultaneous requests: exactly one grant per IDLE cycle. Fairness means every pending requester is served within NREQ operations.
- `req_vld` dropped before acceptance: no grant, no state change.
- Reset mid-operation:
  - Any in-flight response is discarded.
  - The divider, which has no reset, may still be busy. The next ISSUE waits for `div_output_vld`=1, so no start pulse is ever sent to a busy divider.

## Test plan
- **Single request:** req 0: A=100, B=7 → `req_rdy[0]` in the same cycle; `resp_vld[0]` 36 cycles later; Q=14, R=2, dz=0.
- **Signed operands:** req 2: A=-100, B=7 → Q=-14, R=-2. Then A=100, B=-7 → Q=-14, R=2.
- **Contention:** all four requesters hold `req_vld` from reset. Grants go in order 0,1,2,3. Each response matches its own operands, and only the owner's `resp_vld` bit pulses.
- **Round-robin fairness:** with `ptr`=2 and requesters 0 and 3 pending → grant 3 first, then 0.
- **Divide by zero:** req 1: A=55, B=0 → `resp_vld[1]` 2 cycles after acceptance; Q=0xFFFFFFFF, R=55, dz=1. `div_input_vld` never asserts.
- **Reset mid-operation:** assert `rst` 10 cycles after ISSUE, then immediately request A=9, B=3.
  - No `resp_vld` for the old operation.
  - The new ISSUE is delayed until the divider returns idle.
  - Response: Q=3, R=0.
